branch_resolver: RTL and testbench

Registered branch-resolution stage that consumes the ALU status flags (negative, zero, overflow, carry) produced by a subtract of the two branch operands. It evaluates the RISC-V conditional-branch condition selected by funct3, computes the redirect address, and checks it against the fetch-stage prediction. It sits between the ALU and the PC-select logic, behind a one-entry valid/ready pipeline register, and keeps saturating branch/mispredict statistics counters.

---
 rtl/branch_resolver.sv | 136 +++++++++++++
 tb/tb_branch_resolver.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - RISC-V conditional-branch resolution stage with a one-entry
// valid/ready output register and saturating branch/mispredict statistics.
module branch_resolver #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inValid,
    output logic             inReady,
    input  logic             negative,
    input  logic             zero,
    input  logic             overflow,
    input  logic             carry,
    input  logic [2:0]       funct3,
    input  logic [31:0]      pc,
    input  logic [31:0]      imm,
    input  logic             predTaken,
    input  logic             flush,
    output logic             outValid,
    input  logic             outReady,
    output logic             taken,
    output logic [31:0]      target,
    output logic             mispredict,
    output logic             illegal,
    output logic [CNT_W-1:0] branchCount,
    output logic [CNT_W-1:0] mispredictCount
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_q;
    logic               taken_q;
    logic [31:0]        target_q;
    logic               misp_q;
    logic               illegal_q;
    logic [CNT_W-1:0]   bcnt_q;
    logic [CNT_W-1:0]   mcnt_q;

    logic               taken_d;
    logic [31:0]        target_d;
    logic               misp_d;
    logic               illegal_d;
    logic [CNT_W-1:0]   bcnt_d;
    logic [CNT_W-1:0]   mcnt_d;

    logic               accept;
    logic               deliver;
    logic               signed_lt;

    assign outValid        = (state_q == FULL);
    assign inReady         = !outValid || outReady;
    assign accept          = inValid && inReady;
    assign deliver         = outValid && outReady;
    assign signed_lt       = negative ^ overflow;

    assign taken           = taken_q;
    assign target          = target_q;
    assign mispredict      = misp_q;
    assign illegal         = illegal_q;
    assign branchCount     = bcnt_q;
    assign mispredictCount = mcnt_q;

    // Branch condition decode from the flags of op1 - op2.
    always_comb begin
        taken_d   = 1'b0;
        illegal_d = 1'b0;
        case (funct3)
            3'b000:  taken_d = zero;
            3'b001:  taken_d = !zero;
            3'b100:  taken_d = signed_lt;
            3'b101:  taken_d = !signed_lt;
            3'b110:  taken_d = carry;
            3'b111:  taken_d = !carry;
            default: illegal_d = 1'b1;
        endcase
        target_d = taken_d ? (pc + imm) : (pc + 32'd4);
        misp_d   = !illegal_d && (taken_d ^ predTaken);
    end

    // Statistics advance on the result leaving the stage, sticking at all-ones.
    always_comb begin
        bcnt_d = bcnt_q;
        mcnt_d = mcnt_q;
        if (deliver) begin
            if (bcnt_q != CNT_MAX) begin
                bcnt_d = bcnt_q + 1'b1;
            end
            if (misp_q && (mcnt_q != CNT_MAX)) begin
                mcnt_d = mcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= EMPTY;
            taken_q   <= 1'b0;
            target_q  <= 32'd0;
            misp_q    <= 1'b0;
            illegal_q <= 1'b0;
            bcnt_q    <= '0;
            mcnt_q    <= '0;
        end else if (flush) begin
            // Flush wins over both handshakes: entry dropped, nothing counted.
            state_q <= EMPTY;
        end else begin
            bcnt_q <= bcnt_d;
            mcnt_q <= mcnt_d;
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_q <= FULL;
                    end
                end
                FULL: begin
                    if (deliver && !accept) begin
                        state_q <= EMPTY;
                    end
                end
                default: state_q <= EMPTY;
            endcase
            if (accept) begin
                taken_q   <= taken_d;
                target_q  <= target_d;
                misp_q    <= misp_d;
                illegal_q <= illegal_d;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - directed and random checks of branch_resolver against an
// operand-level reference model.
module tb_branch_resolver;

    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          inValid;
    logic          inReady;
    logic          negative, zero, overflow, carry;
    logic [2:0]    funct3;
    logic [31:0]   pc, imm;
    logic          predTaken;
    logic          flush;
    logic          outValid;
    logic          outReady;
    logic          taken;
    logic [31:0]   target;
    logic          mispredict;
    logic          illegal;
    logic [CW-1:0] branchCount;
    logic [CW-1:0] mispredictCount;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] op_a, op_b;

    // Reference model state
    logic        m_valid, m_taken, m_misp, m_ill;
    logic [31:0] m_target;
    int          m_bc, m_mc;

    branch_resolver #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
        .negative(negative), .zero(zero), .overflow(overflow), .carry(carry),
        .funct3(funct3), .pc(pc), .imm(imm), .predTaken(predTaken), .flush(flush),
        .outValid(outValid), .outReady(outReady), .taken(taken), .target(target),
        .mispredict(mispredict), .illegal(illegal), .branchCount(branchCount),
        .mispredictCount(mispredictCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("outValid", {31'd0, outValid}, {31'd0, m_valid});
        chk("taken", {31'd0, taken}, {31'd0, m_taken});
        chk("target", target, m_target);
        chk("mispredict", {31'd0, mispredict}, {31'd0, m_misp});
        chk("illegal", {31'd0, illegal}, {31'd0, m_ill});
        chk("branchCount", {28'd0, branchCount}, m_bc);
        chk("mispredictCount", {28'd0, mispredictCount}, m_mc);
    endtask

    task automatic model_reset();
        m_valid = 0; m_taken = 0; m_misp = 0; m_ill = 0; m_target = 0; m_bc = 0; m_mc = 0;
    endtask

    // Drive operands through an ALU subtract to obtain the flags the DUT sees.
    task automatic drive(input logic v, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] p, input logic [31:0] i,
                         input logic pred, input logic ordy, input logic fl);
        logic [31:0] d;
        op_a = a; op_b = b;
        d = a - b;
        negative  = d[31];
        zero      = (d == 32'd0);
        carry     = (a < b);
        overflow  = (a[31] != b[31]) && (d[31] != a[31]);
        inValid   = v; funct3 = f3; pc = p; imm = i;
        predTaken = pred; outReady = ordy; flush = fl;
    endtask

    function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic cycle();
        logic acc, del;
        #1;
        chk("inReady", {31'd0, inReady}, {31'd0, (!m_valid || outReady)});
        if (flush) begin
            m_valid = 0;
        end else begin
            del = m_valid && outReady;
            acc = inValid && (!m_valid || outReady);
            if (del) begin
                if (m_bc < CMAX) m_bc++;
                if (m_misp && m_mc < CMAX) m_mc++;
            end
            if (acc) begin
                m_ill    = (funct3 == 3'd2) || (funct3 == 3'd3);
                m_taken  = ref_taken(funct3, op_a, op_b);
                m_target = m_taken ? pc + imm : pc + 32'd4;
                m_misp   = !m_ill && (m_taken != predTaken);
                m_valid  = 1;
            end else if (del) begin
                m_valid = 0;
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        model_reset();
        reset = 1'b1;
        drive(0, 3'd0, 0, 0, 0, 0, 0, 1, 0);
        #2;
        check_outputs();
        chk("reset_inReady", {31'd0, inReady}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;

        // Flag decode per funct3
        drive(1, 3'd0, 32'd5, 32'd5, 32'h100, 32'h20, 1, 1, 0); cycle();
        chk("beq_taken", {31'd0, taken}, 32'd1);
        chk("beq_target", target, 32'h120);
        drive(1, 3'd6, 32'd10, 32'd3, 32'h100, 32'h40, 0, 1, 0); cycle();
        chk("bltu_target", target, 32'h104);
        drive(1, 3'd4, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h200, 32'h10, 0, 1, 0); cycle();
        chk("blt_nv_taken", {31'd0, taken}, 32'd0);
        drive(1, 3'd5, 32'h80000000, 32'd1, 32'h300, 32'h10, 0, 1, 0); cycle();
        chk("bge_v_taken", {31'd0, taken}, 32'd0);

        // Mispredict with fall-through wrap
        drive(1, 3'd0, 32'd1, 32'd2, 32'hFFFFFFFC, 32'h8, 1, 1, 0); cycle();
        chk("wrap_target", target, 32'h0);
        chk("wrap_misp", {31'd0, mispredict}, 32'd1);
        drive(0, 3'd0, 0, 0, 0, 0, 0, 1, 0); cycle();

        // Backpressure: hold A, B waits, then deliver A and accept B on one edge
        drive(1, 3'd1, 32'd1, 32'd9, 32'h400, 32'h40, 0, 1, 0); cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1, 3'd7, 32'd3, 32'd9, 32'h500, 32'h80, 1, 0, 0); cycle();
        end
        drive(1, 3'd7, 32'd3, 32'd9, 32'h500, 32'h80, 1, 1, 0); cycle();
        chk("bp_outValid_held", {31'd0, outValid}, 32'd1);
        drive(0, 3'd0, 0, 0, 0, 0, 0, 1, 0); cycle();

        // Illegal funct3
        drive(1, 3'd2, 32'd4, 32'd4, 32'h600, 32'h20, 1, 1, 0); cycle();
        chk("ill_flag", {31'd0, illegal}, 32'd1);
        drive(0, 3'd0, 0, 0, 0, 0, 0, 1, 0); cycle();

        // Flush while FULL with a new branch offered and outReady high
        drive(1, 3'd0, 32'd7, 32'd7, 32'h700, 32'h20, 0, 1, 0); cycle();
        drive(1, 3'd1, 32'd7, 32'd8, 32'h800, 32'h20, 0, 1, 1); cycle();
        chk("flush_outValid", {31'd0, outValid}, 32'd0);
        drive(0, 3'd0, 0, 0, 0, 0, 0, 1, 0); cycle();

        // Asynchronous reset during a stall
        drive(1, 3'd6, 32'd1, 32'd2, 32'h900, 32'h20, 1, 1, 0); cycle();
        drive(1, 3'd6, 32'd1, 32'd2, 32'hA00, 32'h20, 1, 0, 0);
        #3 reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        chk("rst_inReady", {31'd0, inReady}, 32'd1);
        #1 reset = 1'b0;
        drive(0, 3'd0, 0, 0, 0, 0, 0, 1, 0); cycle();

        // Random traffic
        for (int i = 0; i < 80; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, b, $urandom,
                  $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 9) == 0));
            cycle();
        end

        // Saturation: 17 mispredicting deliveries
        for (int i = 0; i < 17; i++) begin
            drive(1, 3'd0, 32'd1, 32'd2, 32'h1000, 32'h20, 1, 1, 0); cycle();
        end
        drive(0, 3'd0, 0, 0, 0, 0, 0, 1, 0); cycle();
        chk("sat_branchCount", {28'd0, branchCount}, 32'd15);
        chk("sat_mispredictCount", {28'd0, mispredictCount}, 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
